control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Microcode sequencer for the 8-bit computer; sits directly upstream of the RAM/MAR stage.
- Drives the RAM/MAR stage's mar_load (MAR load), ram_out (RAM output enable) and ram_write (RAM write control) strobes, plus every other bus/register control.
- Steps a T-state counter, decodes the 4-bit opcode from the instruction register, and produces one control word per T-state.
- Owns the sticky halt state.

Parameters:
- EARLY_END, 1: when 1, the step counter returns to T0 after the last non-empty microstep of the current opcode; when 0, every instruction runs T0..T4.
- LAST_STEP, 4: index of the final T-state (5 states, T0..T4).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- clear  input  1  synchronous, active-high reset
- opcode  input  4  IR[7:4]
- flag_carry  input  1  registered carry flag
- flag_zero  input  1  registered zero flag
- step  output  3  current T-state, 0..LAST_STEP
- halt  output  1  clock-stop request, sticky
- mar_load  output  1  load MAR from bus[3:0]
- ram_out  output  1  RAM drives bus
- ram_write  output  1  RAM write strobe
- ir_load  output  1  load IR from bus
- ir_out  output  1  IR[3:0] onto bus
- pc_inc  output  1  program counter increment
- pc_out  output  1  PC onto bus
- pc_jump  output  1  PC load from bus
- a_load  output  1  load A register
- a_out  output  1  A register onto bus
- b_load  output  1  load B register
- sum_out  output  1  ALU onto bus
- sub  output  1  ALU subtract select
- out_load  output  1  load output register
- flags_load  output  1  latch carry/zero flags

Behaviour:
- State: step[2:0] and the halted flag; both are registered.
- All control outputs are combinational from (step, opcode, flags, halted); no extra latency.
- clear=1 at an edge: step<=0, halted<=0.
- While clear=1: all control outputs and halt are forced to 0, including mid-instruction.

Fetch (every opcode):
- T0: pc_out, mar_load.
- T1: ram_out, ir_load, pc_inc.

Execute, T2..T4 (unlisted steps are empty):
- 0 NOP: none.
- 1 LDA: T2 ir_out+mar_load; T3 ram_out+a_load.
- 2 ADD: T2 ir_out+mar_load; T3 ram_out+b_load; T4 sum_out+a_load+flags_load.
- 3 SUB: same as ADD, plus sub=1 in T4.
- 4 STA: T2 ir_out+mar_load; T3 a_out+ram_write.
- 5 LDI: T2 ir_out+a_load.
- 6 JMP: T2 ir_out+pc_jump.
- 7 JC: T2 ir_out+pc_jump only if flag_carry=1, else empty.
- 8 JZ: as JC, using flag_zero.
- E OUT: T2 a_out+out_load.
- F HLT: T2 halt=1; halted<=1 at the end of T2.
- 9..D: treated as NOP.

Step advance:
- step increments by 1 each clock.
- At LAST_STEP, step wraps to 0.
- With EARLY_END=1, the step after an opcode's last non-empty step is skipped and step goes to 0 instead. Examples: LDI/JMP/OUT return to T0 after T2; LDA/STA after T3; NOP after T1.
- JC/JZ with the flag not taken: T2 is empty and step returns to 0 after T2. This fixed length keeps timing independent of the flag.

Halt:
- Once halted=1: step is frozen, halt=1, every other output is 0.
- Only clear exits the halted state.

Bus contention:
- At most one of pc_out, ram_out, ir_out, a_out, sum_out is asserted in any state; the bench checks this as an assertion.
- ram_write and mar_load are never asserted in the same step.

Test Plan:
- Reset, opcode=0: step sequence 0,1,0,1; T0 shows pc_out=mar_load=1; T1 shows ram_out=ir_load=pc_inc=1.
- opcode=2 (ADD), EARLY_END=1: steps 0,1,2,3,4,0. T4 shows sum_out=a_load=flags_load=1 and sub=0. Repeat with opcode=3: sub=1 only in T4.
- opcode=4 (STA): T3 shows a_out=ram_write=1 and mar_load=0; step returns to 0 after T3.
- opcode=7 (JC): with flag_carry=0, pc_jump=0 at T2; with flag_carry=1, pc_jump=ir_out=1 at T2. Both cases return to T0 after T2.
- opcode=F (HLT): halt rises at T2 and step stays 2 for 10 clocks with all other outputs 0. clear=1 for 1 cycle gives step=0, halt=0.
- Assert clear during T3 of LDA: outputs are 0 during clear, and the next cycle is T0 with pc_out=mar_load=1.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer
// Microcode sequencer for the 8-bit computer. It steps a T-state counter,
// decodes the IR opcode, and emits one control word per T-state. It also
// holds the sticky halt state that stops the machine.
//
// Parameters:
//   EARLY_END  1: return to T0 right after the last non-empty microstep of
//                 the current opcode; 0: every instruction runs T0..LAST_STEP
//   LAST_STEP  index of the final T-state (default 4 -> T0..T4)
//
// Ports:
//   clk        system clock, rising edge
//   clear      synchronous active-high reset; forces all outputs low
//   opcode     IR[7:4]
//   flag_carry registered carry flag (used by JC)
//   flag_zero  registered zero flag (used by JZ)
//   step       current T-state (also serves as the sequencer's state view)
//   halt       sticky clock-stop request
//   mar_load .. flags_load   bus/register control strobes
//
// Handshake note: this block has no valid/ready interfaces. Every output is
// a pure combinational function of (clear, step, halted, opcode, flags) and
// takes effect at the next rising edge in the downstream datapath.

module control_sequencer #(
   parameter bit EARLY_END = 1'b1,
   parameter int LAST_STEP = 4
) (
   input  logic       clk,
   input  logic       clear,
   input  logic [3:0] opcode,
   input  logic       flag_carry,
   input  logic       flag_zero,
   output logic [2:0] step,
   output logic       halt,
   output logic       mar_load,
   output logic       ram_out,
   output logic       ram_write,
   output logic       ir_load,
   output logic       ir_out,
   output logic       pc_inc,
   output logic       pc_out,
   output logic       pc_jump,
   output logic       a_load,
   output logic       a_out,
   output logic       b_load,
   output logic       sum_out,
   output logic       sub,
   output logic       out_load,
   output logic       flags_load
);

   localparam logic [2:0] LAST = LAST_STEP[2:0];

   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   logic       halted;
   logic       halted_next;
   logic [2:0] step_next;
   logic [2:0] op_last;

   // Index of the last microstep this opcode needs. JC/JZ always run T2
   // (empty when not taken) so instruction timing never depends on a flag.
   always_comb begin
      op_last = LAST;
      if (EARLY_END) begin
         unique case (opcode)
            OP_LDA, OP_STA:                 op_last = 3'd3;
            OP_ADD, OP_SUB:                 op_last = 3'd4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ,
            OP_OUT, OP_HLT:                 op_last = 3'd2;
            default:                        op_last = 3'd1;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (clear) begin
         step   <= 3'd0;
         halted <= 1'b0;
      end else begin
         step   <= step_next;
         halted <= halted_next;
      end
   end

   // Next-state logic. HLT at T2 freezes the counter at 2 and sets halted.
   always_comb begin
      step_next   = step;
      halted_next = halted;
      if (!halted) begin
         if (opcode == OP_HLT && step == 3'd2) begin
            halted_next = 1'b1;
         end else if (step >= op_last || step >= LAST) begin
            step_next = 3'd0;
         end else begin
            step_next = step + 3'd1;
         end
      end
   end

   // Output decode
   always_comb begin
      halt       = 1'b0;
      mar_load   = 1'b0;
      ram_out    = 1'b0;
      ram_write  = 1'b0;
      ir_load    = 1'b0;
      ir_out     = 1'b0;
      pc_inc     = 1'b0;
      pc_out     = 1'b0;
      pc_jump    = 1'b0;
      a_load     = 1'b0;
      a_out      = 1'b0;
      b_load     = 1'b0;
      sum_out    = 1'b0;
      sub        = 1'b0;
      out_load   = 1'b0;
      flags_load = 1'b0;
      if (!clear) begin
         if (halted) begin
            halt = 1'b1;
         end else begin
            case (step)
               3'd0: begin
                  pc_out   = 1'b1;
                  mar_load = 1'b1;
               end
               3'd1: begin
                  ram_out = 1'b1;
                  ir_load = 1'b1;
                  pc_inc  = 1'b1;
               end
               3'd2: begin
                  case (opcode)
                     OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ir_out   = 1'b1;
                        mar_load = 1'b1;
                     end
                     OP_LDI: begin
                        ir_out = 1'b1;
                        a_load = 1'b1;
                     end
                     OP_JMP: begin
                        ir_out  = 1'b1;
                        pc_jump = 1'b1;
                     end
                     OP_JC: begin
                        ir_out  = flag_carry;
                        pc_jump = flag_carry;
                     end
                     OP_JZ: begin
                        ir_out  = flag_zero;
                        pc_jump = flag_zero;
                     end
                     OP_OUT: begin
                        a_out    = 1'b1;
                        out_load = 1'b1;
                     end
                     OP_HLT: halt = 1'b1;
                     default: ;
                  endcase
               end
               3'd3: begin
                  case (opcode)
                     OP_LDA: begin
                        ram_out = 1'b1;
                        a_load  = 1'b1;
                     end
                     OP_ADD, OP_SUB: begin
                        ram_out = 1'b1;
                        b_load  = 1'b1;
                     end
                     OP_STA: begin
                        a_out     = 1'b1;
                        ram_write = 1'b1;
                     end
                     default: ;
                  endcase
               end
               3'd4: begin
                  if (opcode == OP_ADD || opcode == OP_SUB) begin
                     sum_out    = 1'b1;
                     a_load     = 1'b1;
                     flags_load = 1'b1;
                     sub        = (opcode == OP_SUB);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer. The reference model describes each
// instruction as the list of control words it should produce, one per
// T-state, and the bench walks the DUT through that list.

module tb_control_sequencer;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       clear = 1'b1;
   logic [3:0] opcode = 4'h0;
   logic       flag_carry = 1'b0;
   logic       flag_zero = 1'b0;
   logic [2:0] step;
   logic       halt;
   logic mar_load, ram_out, ram_write, ir_load, ir_out, pc_inc, pc_out;
   logic pc_jump, a_load, a_out, b_load, sum_out, sub, out_load, flags_load;

   control_sequencer dut (
      .clk        (clk),
      .clear      (clear),
      .opcode     (opcode),
      .flag_carry (flag_carry),
      .flag_zero  (flag_zero),
      .step       (step),
      .halt       (halt),
      .mar_load   (mar_load),
      .ram_out    (ram_out),
      .ram_write  (ram_write),
      .ir_load    (ir_load),
      .ir_out     (ir_out),
      .pc_inc     (pc_inc),
      .pc_out     (pc_out),
      .pc_jump    (pc_jump),
      .a_load     (a_load),
      .a_out      (a_out),
      .b_load     (b_load),
      .sum_out    (sum_out),
      .sub        (sub),
      .out_load   (out_load),
      .flags_load (flags_load)
   );

   // control word packing used by the model
   localparam logic [14:0] MAR  = 15'h4000;
   localparam logic [14:0] RO   = 15'h2000;
   localparam logic [14:0] RW   = 15'h1000;
   localparam logic [14:0] IRL  = 15'h0800;
   localparam logic [14:0] IRO  = 15'h0400;
   localparam logic [14:0] PCI  = 15'h0200;
   localparam logic [14:0] PCO  = 15'h0100;
   localparam logic [14:0] PCJ  = 15'h0080;
   localparam logic [14:0] AL   = 15'h0040;
   localparam logic [14:0] AO   = 15'h0020;
   localparam logic [14:0] BL   = 15'h0010;
   localparam logic [14:0] SO   = 15'h0008;
   localparam logic [14:0] SUBB = 15'h0004;
   localparam logic [14:0] OL   = 15'h0002;
   localparam logic [14:0] FL   = 15'h0001;

   logic [14:0] obs_cw;
   assign obs_cw = {mar_load, ram_out, ram_write, ir_load, ir_out, pc_inc, pc_out,
                    pc_jump, a_load, a_out, b_load, sum_out, sub, out_load, flags_load};

   // scoreboard
   int total_cnt = 0;
   int fail_cnt  = 0;
   logic [14:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // bus contention, sampled away from the active edge
   always @(negedge clk) begin
      if (!clear) begin
         total_cnt++;
         assert ($countones({pc_out, ram_out, ir_out, a_out, sum_out}) <= 1 &&
                 !(ram_write && mar_load)) else begin
            fail_cnt++;
            $error("FAIL bus_contention observed=%0h expected=legal", obs_cw);
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: the microprogram an instruction should run, listing fetch and
   // then its execute words up to its last non-empty step. JC/JZ/HLT keep T2
   // even when it carries no strobe.
   task automatic build_prog(input logic [3:0] op, input logic c, input logic z);
      exp_q = {};
      exp_q.push_back(PCO | MAR);
      exp_q.push_back(RO | IRL | PCI);
      case (op)
         4'h1: begin exp_q.push_back(IRO | MAR); exp_q.push_back(RO | AL); end
         4'h2, 4'h3: begin
            exp_q.push_back(IRO | MAR);
            exp_q.push_back(RO | BL);
            exp_q.push_back(SO | AL | FL | ((op == 4'h3) ? SUBB : 15'h0));
         end
         4'h4: begin exp_q.push_back(IRO | MAR); exp_q.push_back(AO | RW); end
         4'h5: exp_q.push_back(IRO | AL);
         4'h6: exp_q.push_back(IRO | PCJ);
         4'h7: exp_q.push_back(c ? (IRO | PCJ) : 15'h0);
         4'h8: exp_q.push_back(z ? (IRO | PCJ) : 15'h0);
         4'hE: exp_q.push_back(AO | OL);
         4'hF: exp_q.push_back(15'h0);
         default: ;
      endcase
   endtask

   task automatic run_instr(input logic [3:0] op, input logic c, input logic z);
      opcode = op;
      flag_carry = c;
      flag_zero = z;
      build_prog(op, c, z);
      for (int i = 0; i < exp_q.size(); i++) begin
         check($sformatf("op%0h_step%0d", op, i), {29'd0, step}, i);
         check($sformatf("op%0h_cw%0d", op, i), {17'd0, obs_cw}, {17'd0, exp_q[i]});
         check($sformatf("op%0h_halt%0d", op, i), {31'd0, halt},
               (op == 4'hF && i == 2) ? 32'd1 : 32'd0);
         tick();
      end
      check($sformatf("op%0h_end_step", op), {29'd0, step}, (op == 4'hF) ? 32'd2 : 32'd0);
   endtask

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "timeout");
   end

   // directed + random stimulus
   initial begin
      logic [3:0] rop;

      clear = 1'b1;
      tick();
      tick();
      check("reset_step", {29'd0, step}, 0);
      check("reset_halt", {31'd0, halt}, 0);
      check("reset_cw", {17'd0, obs_cw}, 0);
      clear = 1'b0;
      #1;

      run_instr(4'h0, 1'b0, 1'b0);
      run_instr(4'h0, 1'b0, 1'b0);
      run_instr(4'h2, 1'b0, 1'b0);
      run_instr(4'h3, 1'b1, 1'b1);
      run_instr(4'h4, 1'b0, 1'b0);
      run_instr(4'h7, 1'b0, 1'b1);
      run_instr(4'h7, 1'b1, 1'b0);
      run_instr(4'h8, 1'b1, 1'b0);
      run_instr(4'h8, 1'b0, 1'b1);
      run_instr(4'h1, 1'b0, 1'b0);
      run_instr(4'h5, 1'b0, 1'b0);
      run_instr(4'h6, 1'b0, 1'b0);
      run_instr(4'hE, 1'b0, 1'b0);
      for (int k = 9; k <= 13; k++) run_instr(4'(k), 1'b1, 1'b1);

      for (int n = 0; n < 80; n++) begin
         rop = 4'($urandom_range(0, 14));
         run_instr(rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // HLT: frozen at T2 with only halt high
      run_instr(4'hF, 1'b0, 1'b0);
      for (int n = 0; n < 10; n++) begin
         opcode = 4'($urandom_range(0, 15));
         flag_carry = 1'($urandom_range(0, 1));
         check("halted_step", {29'd0, step}, 2);
         check("halted_halt", {31'd0, halt}, 1);
         check("halted_cw", {17'd0, obs_cw}, 0);
         tick();
      end
      clear = 1'b1;
      #1;
      check("clear_halt_forced", {31'd0, halt}, 0);
      check("clear_cw_forced", {17'd0, obs_cw}, 0);
      tick();
      clear = 1'b0;
      #1;
      check("post_clear_step", {29'd0, step}, 0);
      check("post_clear_halt", {31'd0, halt}, 0);

      // clear during T3 of LDA
      opcode = 4'h1;
      tick();
      tick();
      tick();
      check("lda_t3_step", {29'd0, step}, 3);
      check("lda_t3_cw", {17'd0, obs_cw}, {17'd0, RO | AL});
      clear = 1'b1;
      #1;
      check("mid_clear_cw", {17'd0, obs_cw}, 0);
      check("mid_clear_halt", {31'd0, halt}, 0);
      tick();
      clear = 1'b0;
      #1;
      check("after_mid_clear_step", {29'd0, step}, 0);
      check("after_mid_clear_cw", {17'd0, obs_cw}, {17'd0, PCO | MAR});
      run_instr(4'h2, 1'b0, 1'b0);

      // final report
      $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
      $finish;
   end

endmodule
